// File: rtl/spi_pkg.sv
// Shared types for the SPI frame engine: FSM states, mode bundle and the four
// standard CPOL/CPHA mode constants.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_mode_t;

  localparam spi_mode_t SPI_MODE0 = '{cpol: 1'b0, cpha: 1'b0, lsb_first: 1'b0};
  localparam spi_mode_t SPI_MODE1 = '{cpol: 1'b0, cpha: 1'b1, lsb_first: 1'b0};
  localparam spi_mode_t SPI_MODE2 = '{cpol: 1'b1, cpha: 1'b0, lsb_first: 1'b0};
  localparam spi_mode_t SPI_MODE3 = '{cpol: 1'b1, cpha: 1'b1, lsb_first: 1'b0};

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: counts 0..div and ticks on the last count, so
// one tick every div+1 cycles. Clearing or ticking restarts the count at 0.
module spi_clk_div #(
  parameter int DIVW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic [DIVW-1:0] div,
  output logic            tick
);

  logic [DIVW-1:0] cnt;

  assign tick = (cnt == div);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIVW'(1);
    end
  end

endmodule

// File: rtl/spi_xfer_engine.sv
// SPI master frame engine: CS/SCLK generation, all CPOL/CPHA modes, runtime
// length, bit order and divider. Define SPI_RX_EN to build the receive path.
module spi_xfer_engine
  import spi_pkg::*;
#(
  parameter int DW   = 16,
  parameter int LW   = $clog2(DW),
  parameter int DIVW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DW-1:0]   tx_data,
  input  logic [LW-1:0]   len,
  input  logic            cpol,
  input  logic            cpha,
  input  logic            lsb_first,
  input  logic [DIVW-1:0] clk_div,
  input  logic            miso,
  output logic            busy,
  output logic            done,
  output logic [DW-1:0]   rx_data,
  output logic            sclk,
  output logic            mosi,
  output logic            cs_n
);

  localparam logic [LW-1:0] LEN_MAX = LW'(DW - 1);

  spi_state_t      state, state_nxt;
  spi_mode_t       mode_q;
  logic [DW-1:0]   tx_q;
  logic [LW-1:0]   len_q;
  logic [LW-1:0]   bit_cnt;
  logic [DIVW-1:0] div_q;
  logic            phase;
  logic            sclk_q;
  logic            mosi_q;
  logic            done_q;
  logic            tick;

  logic [LW-1:0]   len_c;
  logic [LW-1:0]   first_idx;
  logic [LW-1:0]   cur_idx;
  logic [LW-1:0]   nxt_idx;
  logic            shift_tick;
  logic            last_bit;

  spi_clk_div #(.DIVW(DIVW)) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == IDLE),
    .div  (div_q),
    .tick (tick)
  );

  // Widen before comparing so the clamp stays meaningful when DW is not a power of two.
  assign len_c      = ({1'b0, len} > (LW + 1)'(DW - 1)) ? LEN_MAX : len;
  assign first_idx  = lsb_first ? '0 : len_c;
  assign shift_tick = (state == SHIFT) && tick;
  assign last_bit   = (bit_cnt == '0);

  // bit_cnt counts down from len; LSB-first mirrors it around len.
  always_comb begin
    cur_idx = bit_cnt;
    nxt_idx = bit_cnt - LW'(1);
    if (mode_q.lsb_first) begin
      cur_idx = len_q - bit_cnt;
      nxt_idx = len_q - bit_cnt + LW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETUP;
      SETUP:   if (tick) state_nxt = SHIFT;
      SHIFT:   if (shift_tick && phase && last_bit) state_nxt = HOLD;
      HOLD:    if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    cs_n = (state == IDLE);
    mosi = (state == IDLE) ? 1'b1 : mosi_q;
  end

  assign sclk = sclk_q;
  assign done = done_q;

  // phase=0: next SCLK edge is the leading (odd) edge; phase=1: trailing (even).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q  <= SPI_MODE0;
      tx_q    <= '0;
      len_q   <= '0;
      bit_cnt <= '0;
      div_q   <= '0;
      phase   <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          sclk_q <= cpol;
          if (start) begin
            mode_q  <= '{cpol: cpol, cpha: cpha, lsb_first: lsb_first};
            tx_q    <= tx_data;
            len_q   <= len_c;
            bit_cnt <= len_c;
            div_q   <= clk_div;
            phase   <= 1'b0;
            mosi_q  <= cpha ? 1'b1 : tx_data[first_idx];
          end
        end
        SHIFT: begin
          if (tick) begin
            sclk_q <= ~sclk_q;
            phase  <= ~phase;
            if (!phase) begin
              if (mode_q.cpha) mosi_q <= tx_q[cur_idx];
            end else begin
              if (!mode_q.cpha && !last_bit) mosi_q <= tx_q[nxt_idx];
              bit_cnt <= bit_cnt - LW'(1);
            end
          end
        end
        HOLD: begin
          if (tick) done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_RX_EN
  logic [DW-1:0] rx_sh;
  logic [DW-1:0] rx_q;

  // Sample on the leading edge for cpha=0 and the trailing edge for cpha=1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sh <= '0;
      rx_q  <= '0;
    end else begin
      if (state == IDLE && start) begin
        rx_sh <= '0;
      end else if (shift_tick && (phase == mode_q.cpha)) begin
        rx_sh[cur_idx] <= miso;
      end
      if (state == HOLD && tick) rx_q <= rx_sh;
    end
  end

  assign rx_data = rx_q;
`else
  logic unused_miso;
  assign unused_miso = miso;
  assign rx_data     = '0;
`endif

endmodule

// File: tb/tb_spi_xfer_engine.sv
// Self-checking bench for spi_xfer_engine: table-driven frames with a
// scoreboard of expected done cycle, rx word and serial bit sequence.
module tb_spi_xfer_engine;
  import spi_pkg::*;

  localparam int DW   = 16;
  localparam int LW   = 4;
  localparam int DIVW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [DW-1:0]   tx_data = '0;
  logic [LW-1:0]   len = '0;
  logic            cpol = 1'b0;
  logic            cpha = 1'b0;
  logic            lsb_first = 1'b0;
  logic [DIVW-1:0] clk_div = '0;
  logic            inv = 1'b0;
  logic            miso;
  logic            busy, done, sclk, mosi, cs_n;
  logic [DW-1:0]   rx_data;

  assign miso = mosi ^ inv;

  always #5 clk = ~clk;

  spi_xfer_engine #(.DW(DW), .LW(LW), .DIVW(DIVW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .tx_data   (tx_data),
    .len       (len),
    .cpol      (cpol),
    .cpha      (cpha),
    .lsb_first (lsb_first),
    .clk_div   (clk_div),
    .miso      (miso),
    .busy      (busy),
    .done      (done),
    .rx_data   (rx_data),
    .sclk      (sclk),
    .mosi      (mosi),
    .cs_n      (cs_n)
  );

  typedef struct {
    string           name;
    logic            cpol;
    logic            cpha;
    logic            lsb;
    logic [LW-1:0]   len;
    logic [DIVW-1:0] div;
    logic [DW-1:0]   tx;
    logic            inv;
  } vec_t;

  typedef struct {
    string         name;
    logic [DW-1:0] rx;
    int            done_cyc;
    logic [DW-1:0] seq;
    int            nbits;
    logic          cpol;
    logic          cpha;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t make_exp(input vec_t v, input int t0);
    exp_t        e;
    int          h, n;
    logic [31:0] m;
    h = int'(v.div) + 1;
    n = int'(v.len) + 1;
    m = (32'd1 << n) - 32'd1;
    e.name     = v.name;
    e.done_cyc = t0 + 1 + h * (2 * n + 2);
    e.nbits    = n;
    e.cpol     = v.cpol;
    e.cpha     = v.cpha;
    e.seq      = '0;
    for (int k = 0; k < n; k++) e.seq[k] = v.lsb ? v.tx[k] : v.tx[n - 1 - k];
`ifdef SPI_RX_EN
    e.rx = DW'(32'(v.tx ^ (v.inv ? {DW{1'b1}} : {DW{1'b0}})) & m);
`else
    e.rx = '0;
`endif
    return e;
  endfunction

  // Monitor: capture mosi on each slave sampling edge; score each done pulse.
  logic          sclk_prev = 1'b0;
  logic          cs_prev = 1'b1;
  int            edges = 0;
  int            ncap = 0;
  logic [DW-1:0] cap = '0;

  always @(negedge clk) begin
    if (cs_prev && !cs_n) begin
      edges = 0;
      ncap  = 0;
      cap   = '0;
    end
    if (!cs_n && !cs_prev && (sclk !== sclk_prev)) begin
      edges++;
      if (((edges % 2) == 1) == !(sb.size() > 0 && sb[0].cpha)) begin
        if (ncap < DW) cap[ncap] = mosi;
        ncap++;
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      check("done_has_pending_frame", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "/done_cycle"}, cyc, e.done_cyc);
        check({e.name, "/rx_data"}, 32'(rx_data), 32'(e.rx));
        check({e.name, "/sclk_edges"}, edges, 2 * e.nbits);
        check({e.name, "/mosi_bits"}, 32'(cap), 32'(e.seq));
        check({e.name, "/cs_n_at_done"}, 32'(cs_n), 32'd1);
        check({e.name, "/busy_at_done"}, 32'(busy), 32'd0);
        check({e.name, "/sclk_idle_at_done"}, 32'(sclk), 32'(e.cpol));
      end
    end
    sclk_prev = sclk;
    cs_prev   = cs_n;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      step();
      n++;
    end
    check({name, "/done_count"}, done_cnt, target);
  endtask

  task automatic launch(input vec_t v);
    cpol      = v.cpol;
    cpha      = v.cpha;
    lsb_first = v.lsb;
    len       = v.len;
    clk_div   = v.div;
    tx_data   = v.tx;
    inv       = v.inv;
    start     = 1'b1;
    sb.push_back(make_exp(v, cyc));
    step();
    start = 1'b0;
    check({v.name, "/cs_n_cycle1"}, 32'(cs_n), 32'd0);
    check({v.name, "/busy_cycle1"}, 32'(busy), 32'd1);
    // Inputs are don't-care once captured.
    tx_data   = DW'($urandom);
    len       = LW'($urandom);
    clk_div   = DIVW'($urandom);
    lsb_first = 1'($urandom);
  endtask

  vec_t tbl[7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int   base;
    vec_t v;

    tbl[0] = '{"m0_msb_a5",     1'b0, 1'b0, 1'b0, 4'd7,  8'd0, 16'h00A5, 1'b0};
    tbl[1] = '{"m3_lsb_1234",   1'b1, 1'b1, 1'b1, 4'd15, 8'd3, 16'h1234, 1'b0};
    tbl[2] = '{"m1_len0",       1'b0, 1'b1, 1'b0, 4'd0,  8'd0, 16'h0001, 1'b0};
    tbl[3] = '{"m2_len0",       1'b1, 1'b0, 1'b0, 4'd0,  8'd0, 16'h0001, 1'b0};
    tbl[4] = '{"m0_lsb_inv",    1'b0, 1'b0, 1'b1, 4'd11, 8'd2, 16'h0ABC, 1'b1};
    tbl[5] = '{"m1_len4_upper", 1'b0, 1'b1, 1'b0, 4'd4,  8'd1, 16'hFFF5, 1'b0};
    tbl[6] = '{"m2_lsb_inv",    1'b1, 1'b0, 1'b1, 4'd15, 8'd0, 16'h8001, 1'b1};

    #2 rst = 1'b0;
    repeat (3) step();
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/done", 32'(done), 32'd0);
    check("reset/rx_data", 32'(rx_data), 32'd0);
    check("reset/sclk", 32'(sclk), 32'd0);
    check("reset/mosi", 32'(mosi), 32'd1);
    check("reset/cs_n", 32'(cs_n), 32'd1);
    rst = 1'b1;
    step();

    cpol = 1'b1;
    repeat (2) step();
    check("idle/sclk_follows_cpol", 32'(sclk), 32'd1);
    cpol = 1'b0;
    repeat (2) step();

    for (int i = 0; i < 7; i++) begin
      base = done_cnt;
      launch(tbl[i]);
      wait_frames(base + 1, 200, tbl[i].name);
      step();
      check({tbl[i].name, "/idle_sclk"}, 32'(sclk), 32'(tbl[i].cpol));
      check({tbl[i].name, "/idle_mosi"}, 32'(mosi), 32'd1);
    end

    // start pulsed mid-frame must be ignored
    base = done_cnt;
    v = '{"midstart", 1'b0, 1'b0, 1'b0, 4'd7, 8'd1, 16'h003C, 1'b0};
    launch(v);
    repeat (8) step();
    tx_data = 16'hFFFF;
    start   = 1'b1;
    step();
    start = 1'b0;
    wait_frames(base + 1, 100, "midstart");
    repeat (40) step();
    check("midstart/single_done", done_cnt - base, 1);

    // asynchronous reset during SHIFT aborts without done
    base = done_cnt;
    v = '{"rst_abort", 1'b0, 1'b1, 1'b0, 4'd15, 8'd2, 16'hBEEF, 1'b0};
    launch(v);
    repeat (20) step();
    #2 rst = 1'b0;
    #1;
    check("rst_abort/cs_n", 32'(cs_n), 32'd1);
    check("rst_abort/mosi", 32'(mosi), 32'd1);
    check("rst_abort/sclk", 32'(sclk), 32'd0);
    check("rst_abort/busy", 32'(busy), 32'd0);
    check("rst_abort/done", 32'(done), 32'd0);
    void'(sb.pop_back());
    step();
    rst = 1'b1;
    repeat (120) step();
    check("rst_abort/no_done", done_cnt - base, 0);
    v = '{"post_rst", 1'b0, 1'b0, 1'b0, 4'd7, 8'd0, 16'h005A, 1'b0};
    launch(v);
    wait_frames(base + 1, 100, "post_rst");

    // start held high: back-to-back frames, one done each
    base = done_cnt;
    v = '{"b2b", 1'b0, 1'b0, 1'b0, 4'd3, 8'd0, 16'h0009, 1'b0};
    cpol      = v.cpol;
    cpha      = v.cpha;
    lsb_first = v.lsb;
    len       = v.len;
    clk_div   = v.div;
    tx_data   = v.tx;
    inv       = v.inv;
    start     = 1'b1;
    for (int k = 0; k < 3; k++) sb.push_back(make_exp(v, cyc + 11 * k));
    wait_frames(base + 2, 60, "b2b_first_two");
    step();
    start = 1'b0;
    wait_frames(base + 3, 60, "b2b_third");
    repeat (20) step();
    check("b2b/total_dones", done_cnt - base, 3);

    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
